// File: rtl/chimpo_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : chimpo_run_ctrl_if
// Brief    : Control/status bundle between board or bench and chimpo_run_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface chimpo_run_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 16
);
  logic             run;
  logic             step;
  logic             halt_req;
  logic             soft_rst;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bkpt_addr;
  logic             bkpt_valid;
  logic             cpu_reset;
  logic             cpu_en;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       state;

  modport master (
    output run, step, halt_req, soft_rst, pc, bkpt_addr, bkpt_valid,
    input  cpu_reset, cpu_en, halted, cycle_count, state
  );

  modport slave (
    input  run, step, halt_req, soft_rst, pc, bkpt_addr, bkpt_valid,
    output cpu_reset, cpu_en, halted, cycle_count, state
  );
endinterface
`default_nettype wire

// File: rtl/chimpo_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chimpo_run_ctrl
// Brief    : Run/reset sequencer for the Chimpo datapath: timed reset hold,
//            free-run, single-step, halt, cycle limit and executed-cycle count.
//            Optional breakpoint halt enabled by `define CHIMPO_RUNCTL_BKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chimpo_run_ctrl #(
  parameter int RST_HOLD_CYCLES = 10,
  parameter int CNT_W           = 32,
  parameter int MAX_CYCLES      = 0,
  parameter int PC_W            = 16
) (
  input  wire logic         CLK,
  input  wire logic         reset,
  chimpo_run_ctrl_if.slave  bus
);

  localparam logic [2:0] C_ST_RST_HOLD = 3'd0;
  localparam logic [2:0] C_ST_IDLE     = 3'd1;
  localparam logic [2:0] C_ST_RUN      = 3'd2;
  localparam logic [2:0] C_ST_STEP     = 3'd3;
  localparam logic [2:0] C_ST_HALTED   = 3'd4;

  localparam int               C_HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    C_MAX       = CNT_W'(MAX_CYCLES);

  logic [2:0]          state_q, state_d;
  logic [C_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                step_q, step_d;

  logic                w_exec;
  logic                w_step_rise;
  logic                w_limit;
  logic                w_bkpt_hit;
  logic [CNT_W-1:0]    w_count_inc;

`ifdef CHIMPO_RUNCTL_BKPT_EN
  logic [PC_W-1:0] w_pc_diff;
  assign w_pc_diff  = bus.pc ^ bus.bkpt_addr;
  assign w_bkpt_hit = bus.bkpt_valid && (w_pc_diff == '0);
`else
  logic [PC_W-1:0] unused_pc_bits;
  logic            unused_bkpt_valid;
  assign unused_pc_bits    = bus.pc ^ bus.bkpt_addr;
  assign unused_bkpt_valid = bus.bkpt_valid;
  assign w_bkpt_hit        = 1'b0;
`endif

  assign w_exec      = (state_q == C_ST_RUN) || (state_q == C_ST_STEP);
  assign w_step_rise = bus.step && !step_q;
  // Saturating increment; the limit compares against the post-increment value so
  // exactly MAX_CYCLES enabled cycles occur before HALTED.
  assign w_count_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
  assign w_limit     = (MAX_CYCLES != 0) && (w_count_inc >= C_MAX);

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = w_exec ? w_count_inc : cycle_count_q;
    step_d        = bus.step;
    if (bus.soft_rst) begin
      state_d       = C_ST_RST_HOLD;
      hold_cnt_d    = '0;
      cycle_count_d = '0;
    end else begin
      case (state_q)
        C_ST_RST_HOLD: begin
          if (hold_cnt_q == C_HOLD_LAST) begin
            state_d    = C_ST_IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        C_ST_IDLE: begin
          if (bus.run)          state_d = C_ST_RUN;
          else if (w_step_rise) state_d = C_ST_STEP;
        end
        C_ST_RUN: begin
          if (bus.halt_req || w_limit || w_bkpt_hit) state_d = C_ST_HALTED;
          else if (!bus.run)                         state_d = C_ST_IDLE;
        end
        C_ST_STEP:   state_d = C_ST_IDLE;
        C_ST_HALTED: state_d = C_ST_HALTED;
        default: begin
          state_d    = C_ST_RST_HOLD;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= C_ST_RST_HOLD;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      step_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      step_q        <= step_d;
    end
  end

  assign bus.cpu_reset   = (state_q == C_ST_RST_HOLD);
  assign bus.cpu_en      = w_exec;
  assign bus.halted      = (state_q == C_ST_HALTED);
  assign bus.cycle_count = cycle_count_q;
  assign bus.state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_chimpo_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chimpo_run_ctrl
// Brief    : Self-checking bench: three controller instances (unlimited,
//            MAX_CYCLES=8, 4-bit counter) against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chimpo_run_ctrl;

  localparam int HOLD = 10;
  // Encoded state values as published on the state output.
  localparam int M_HOLD = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;
`ifdef CHIMPO_RUNCTL_BKPT_EN
  localparam bit BKPT = 1'b1;
`else
  localparam bit BKPT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        run, step, halt_req, soft_rst, bkpt_valid;
  logic [15:0] pc, bkpt_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  chimpo_run_ctrl_if #(.CNT_W(32), .PC_W(16)) if0 ();
  chimpo_run_ctrl_if #(.CNT_W(32), .PC_W(16)) if1 ();
  chimpo_run_ctrl_if #(.CNT_W(4),  .PC_W(16)) if2 ();

  assign if0.run = run;  assign if0.step = step;  assign if0.halt_req = halt_req;
  assign if0.soft_rst = soft_rst;  assign if0.pc = pc;  assign if0.bkpt_addr = bkpt_addr;
  assign if0.bkpt_valid = bkpt_valid;
  assign if1.run = run;  assign if1.step = step;  assign if1.halt_req = halt_req;
  assign if1.soft_rst = soft_rst;  assign if1.pc = pc;  assign if1.bkpt_addr = bkpt_addr;
  assign if1.bkpt_valid = bkpt_valid;
  assign if2.run = run;  assign if2.step = step;  assign if2.halt_req = halt_req;
  assign if2.soft_rst = soft_rst;  assign if2.pc = pc;  assign if2.bkpt_addr = bkpt_addr;
  assign if2.bkpt_valid = bkpt_valid;

  chimpo_run_ctrl #(.RST_HOLD_CYCLES(HOLD), .CNT_W(32), .MAX_CYCLES(0), .PC_W(16))
    dut0 (.CLK(CLK), .reset(reset), .bus(if0.slave));
  chimpo_run_ctrl #(.RST_HOLD_CYCLES(HOLD), .CNT_W(32), .MAX_CYCLES(8), .PC_W(16))
    dut1 (.CLK(CLK), .reset(reset), .bus(if1.slave));
  chimpo_run_ctrl #(.RST_HOLD_CYCLES(HOLD), .CNT_W(4), .MAX_CYCLES(0), .PC_W(16))
    dut2 (.CLK(CLK), .reset(reset), .bus(if2.slave));

  // ---------------- reference model ----------------
  int     m_mode [3];
  int     m_hold [3];
  longint m_cnt  [3];
  bit     m_prev_step;

  function automatic int lim_of(int i);
    return (i == 1) ? 8 : 0;
  endfunction

  function automatic int width_of(int i);
    return (i == 2) ? 4 : 32;
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = M_HOLD;
      m_hold[i] = HOLD;
      m_cnt[i]  = 0;
    end
    m_prev_step = 1'b0;
  endfunction

  function automatic void model_step();
    bit rise = step && !m_prev_step;
    for (int i = 0; i < 3; i++) begin
      longint top  = (longint'(1) << width_of(i)) - 1;
      bit     exec = (m_mode[i] == M_RUN) || (m_mode[i] == M_STEP);
      longint nc   = exec ? ((m_cnt[i] < top) ? m_cnt[i] + 1 : top) : m_cnt[i];
      if (soft_rst) begin
        m_mode[i] = M_HOLD;
        m_hold[i] = HOLD;
        m_cnt[i]  = 0;
      end else begin
        m_cnt[i] = nc;
        case (m_mode[i])
          M_HOLD: begin
            m_hold[i]--;
            if (m_hold[i] == 0) m_mode[i] = M_IDLE;
          end
          M_IDLE: begin
            if (run)       m_mode[i] = M_RUN;
            else if (rise) m_mode[i] = M_STEP;
          end
          M_RUN: begin
            if (halt_req || (lim_of(i) != 0 && nc >= lim_of(i)) ||
                (BKPT && bkpt_valid && pc == bkpt_addr))
              m_mode[i] = M_HALT;
            else if (!run)
              m_mode[i] = M_IDLE;
          end
          M_STEP:  m_mode[i] = M_IDLE;
          default: m_mode[i] = M_HALT;
        endcase
      end
    end
    m_prev_step = step;
  endfunction

  function automatic logic [63:0] exp_word(int i);
    logic [2:0]  st = 3'(m_mode[i]);
    logic [31:0] c  = 32'(m_cnt[i]);
    return {26'd0, st, (m_mode[i] == M_HOLD), (m_mode[i] == M_RUN || m_mode[i] == M_STEP),
            (m_mode[i] == M_HALT), c};
  endfunction

  function automatic logic [63:0] obs_word(int i);
    case (i)
      0:       return {26'd0, if0.state, if0.cpu_reset, if0.cpu_en, if0.halted, if0.cycle_count};
      1:       return {26'd0, if1.state, if1.cpu_reset, if1.cpu_en, if1.halted, if1.cycle_count};
      default: return {26'd0, if2.state, if2.cpu_reset, if2.cpu_en, if2.halted, 28'd0, if2.cycle_count};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 ns later.
  task automatic tick();
    @(posedge CLK);
    if (!reset) model_init();
    else        model_step();
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("cyc_inst%0d", i), obs_word(i), exp_word(i));
  endtask

  int en0, en1;

  initial begin
    reset = 1'b0; run = 0; step = 0; halt_req = 0; soft_rst = 0;
    bkpt_valid = 0; pc = 16'h0; bkpt_addr = 16'h0006;
    model_init();

    repeat (3) tick();
    check("rst_state", 64'(if0.state), 64'(M_HOLD));
    check("rst_cpu_reset", 64'(if0.cpu_reset), 64'd1);
    reset = 1'b1;
    en0 = 0;
    repeat (HOLD) begin
      tick();
      en0 += int'(if0.cpu_reset);
    end
    check("hold_cycles", 64'(en0), 64'd9);
    check("hold_done_state", 64'(if0.state), 64'(M_IDLE));
    check("hold_done_cnt", 64'(if0.cycle_count), 64'd0);

    // free-run 25 cycles; instance 1 auto-halts at 8
    run = 1; en0 = 0; en1 = 0;
    repeat (25) begin
      tick();
      en0 += int'(if0.cpu_en);
      en1 += int'(if1.cpu_en);
    end
    run = 0;
    tick();
    en0 += int'(if0.cpu_en);
    check("run25_en", 64'(en0), 64'd25);
    check("run25_cnt", 64'(if0.cycle_count), 64'd25);
    check("run25_idle", 64'(if0.state), 64'(M_IDLE));
    check("lim_en", 64'(en1), 64'd8);
    check("lim_cnt", 64'(if1.cycle_count), 64'd8);
    check("lim_halted", 64'(if1.halted), 64'd1);
    check("sat_cnt", 64'(if2.cycle_count), 64'd15);

    // single steps: three short pulses and one long one
    en0 = 0;
    repeat (3) begin
      step = 1; tick(); en0 += int'(if0.cpu_en);
      step = 0; tick(); en0 += int'(if0.cpu_en);
      tick(); en0 += int'(if0.cpu_en);
    end
    step = 1;
    repeat (5) begin tick(); en0 += int'(if0.cpu_en); end
    step = 0;
    repeat (3) begin tick(); en0 += int'(if0.cpu_en); end
    check("step_en", 64'(en0), 64'd4);
    check("step_cnt", 64'(if0.cycle_count), 64'd29);
    check("lim_ignores_step", 64'(if1.cycle_count), 64'd8);

    // halt then soft restart
    run = 1;
    repeat (4) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    check("halt_en", 64'(if0.cpu_en), 64'd0);
    check("halt_flag", 64'(if0.halted), 64'd1);
    tick();
    check("halt_ignores_run", 64'(if0.state), 64'(M_HALT));
    soft_rst = 1;
    tick();
    soft_rst = 0; run = 0;
    check("soft_state", 64'(if0.state), 64'(M_HOLD));
    check("soft_cnt", 64'(if0.cycle_count), 64'd0);
    repeat (HOLD) tick();
    check("soft_hold_done", 64'(if0.state), 64'(M_IDLE));

    // breakpoint scenario: pc advances by 2, bkpt at 6
    bkpt_valid = 1; pc = 16'h0; run = 1;
    repeat (8) begin tick(); pc = pc + 16'd2; end
    check("bkpt_state", 64'(if0.state), BKPT ? 64'(M_HALT) : 64'(M_RUN));
    run = 0; bkpt_valid = 0; soft_rst = 1;
    tick();
    soft_rst = 0;
    repeat (HOLD) tick();

    // asynchronous reset in the middle of RUN
    run = 1;
    repeat (3) tick();
    #1 reset = 1'b0;
    #1;
    check("async_en", 64'(if0.cpu_en), 64'd0);
    check("async_cnt", 64'(if0.cycle_count), 64'd0);
    model_init();
    tick();
    reset = 1'b1; run = 0;
    repeat (HOLD + 1) tick();

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step       = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 49) == 0);
      soft_rst   = ($urandom_range(0, 149) == 0);
      bkpt_valid = 1'($urandom_range(0, 1));
      pc         = ($urandom_range(0, 7) == 0) ? bkpt_addr : pc + 16'd2;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
